// File: rtl/fb_pkg.sv
// Shared framebuffer types and defaults used by the swap controller, memory and config blocks.
package fb_pkg;

  typedef enum logic [1:0] {
    SWP_IDLE  = 2'd0,
    SWP_ARMED = 2'd1,
    SWP_GUARD = 2'd2
  } swap_state_t;

  localparam int FB_GUARD_CYCLES = 4;
  localparam int FB_FRAME_W      = 16;

endpackage

// File: rtl/frame_swap_ctrl_if.sv
// Config-decode / buffer-mux side signals of the framebuffer swap controller.
interface frame_swap_ctrl_if
  import fb_pkg::*;
#(
  parameter int FRAME_W = FB_FRAME_W
);
  logic               vblank;
  logic               swap_req;
  logic               immediate;
  logic               nmi_enable;
  logic               nmi_ack;
  logic               buf_sel;
  logic               swap_pending;
  logic               cpu_write_block;
  logic               nmi_n;
  logic [FRAME_W-1:0] frame_count;
  logic [7:0]         flip_count;

  modport master (
    output vblank, swap_req, immediate, nmi_enable, nmi_ack,
    input  buf_sel, swap_pending, cpu_write_block, nmi_n, frame_count, flip_count
  );

  modport slave (
    input  vblank, swap_req, immediate, nmi_enable, nmi_ack,
    output buf_sel, swap_pending, cpu_write_block, nmi_n, frame_count, flip_count
  );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector: o_rise is high the cycle after i_d is first sampled high.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;
  logic r_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q    <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_q    <= i_d;
      r_rise <= i_d & ~r_q;
    end
  end

  assign o_rise = r_rise;
endmodule

// File: rtl/frame_swap_ctrl.sv
// Double-buffer swap sequencer: flips BufSel on VBlank (or immediately), guards CPU writes
// around the flip, and owns the latched VBlank NMI.
module frame_swap_ctrl
  import fb_pkg::*;
#(
  parameter int GUARD_CYCLES = FB_GUARD_CYCLES,
  parameter int FRAME_W      = FB_FRAME_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  frame_swap_ctrl_if.slave        bus
);
  localparam int                CNT_W    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);

  swap_state_t        r_state,     w_state_nxt;
  logic [CNT_W-1:0]   r_guard_cnt, w_guard_cnt_nxt;
  logic               r_rearm,     w_rearm_nxt;
  logic               w_flip;
  logic               w_vb_rise;
  logic               r_buf_sel;
  logic               r_swap_pending;
  logic               r_cpu_write_block;
  logic               r_nmi_n;
  logic [FRAME_W-1:0] r_frame_count;
  logic [7:0]         r_flip_count;

  rise_detect u_vb_rise (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.vblank),
    .o_rise  (w_vb_rise)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_guard_cnt_nxt = r_guard_cnt;
    w_rearm_nxt     = r_rearm;
    w_flip          = 1'b0;
    unique case (r_state)
      SWP_IDLE: begin
        if (bus.swap_req) begin
          if (bus.immediate) begin
            w_state_nxt     = SWP_GUARD;
            w_guard_cnt_nxt = CNT_LOAD;
          end else begin
            w_state_nxt = SWP_ARMED;
          end
        end
      end
      SWP_ARMED: begin
        if (w_vb_rise || bus.immediate) begin
          w_state_nxt     = SWP_GUARD;
          w_guard_cnt_nxt = CNT_LOAD;
        end
      end
      SWP_GUARD: begin
        if (bus.swap_req) w_rearm_nxt = 1'b1;
        // A request landing on the final guard cycle is queued like any earlier one.
        if (r_guard_cnt == '0) begin
          w_flip      = 1'b1;
          w_rearm_nxt = 1'b0;
          w_state_nxt = (r_rearm || bus.swap_req) ? SWP_ARMED : SWP_IDLE;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt - 1'b1;
        end
      end
      default: w_state_nxt = SWP_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state           <= SWP_IDLE;
      r_guard_cnt       <= '0;
      r_rearm           <= 1'b0;
      r_buf_sel         <= 1'b0;
      r_swap_pending    <= 1'b0;
      r_cpu_write_block <= 1'b0;
      r_nmi_n           <= 1'b1;
      r_frame_count     <= '0;
      r_flip_count      <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_guard_cnt       <= w_guard_cnt_nxt;
      r_rearm           <= w_rearm_nxt;
      // Outputs are registered from next-state so the write gate and NMI never glitch.
      r_swap_pending    <= (w_state_nxt != SWP_IDLE) | w_rearm_nxt;
      r_cpu_write_block <= (w_state_nxt == SWP_GUARD);
      if (w_flip) begin
        r_buf_sel    <= ~r_buf_sel;
        r_flip_count <= r_flip_count + 8'd1;
      end
      if (w_vb_rise) r_frame_count <= r_frame_count + 1'b1;
      if (w_vb_rise && bus.nmi_enable)          r_nmi_n <= 1'b0;
      else if (bus.nmi_ack || !bus.nmi_enable)  r_nmi_n <= 1'b1;
    end
  end

  assign bus.buf_sel         = r_buf_sel;
  assign bus.swap_pending    = r_swap_pending;
  assign bus.cpu_write_block = r_cpu_write_block;
  assign bus.nmi_n           = r_nmi_n;
  assign bus.frame_count     = r_frame_count;
  assign bus.flip_count      = r_flip_count;
endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Directed bench for frame_swap_ctrl: per-cycle vector table plus hand-written flip/NMI sequences.
module tb_frame_swap_ctrl;
  import fb_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  frame_swap_ctrl_if #(.FRAME_W(16)) fs_if ();
  frame_swap_ctrl_if #(.FRAME_W(8))  w8_if ();

  frame_swap_ctrl #(.GUARD_CYCLES(4), .FRAME_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (fs_if)
  );

  frame_swap_ctrl #(.GUARD_CYCLES(4), .FRAME_W(8)) dut_w8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (w8_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {swap_req, immediate, vblank, nmi_enable, nmi_ack} -> {buf_sel, swap_pending, cpu_write_block, nmi_n}
  typedef struct packed {
    logic sr, im, vb, en, ak;
    logic buf_sel, pend, blk, nmi_n;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fs_if.swap_req   = 1'b0;
    fs_if.immediate  = 1'b0;
    fs_if.vblank     = 1'b0;
    fs_if.nmi_enable = 1'b0;
    fs_if.nmi_ack    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_buf(input logic val, input string name);
    for (int k = 0; k < 12; k++) begin
      if (fs_if.buf_sel === val) break;
      step();
    end
    check(name, 32'(fs_if.buf_sel), 32'(val));
  endtask

  initial begin
    int   lat;
    int   blk_cnt;
    logic pend_prev;
    logic pend_at_flip;

    rst_n = 1'b0;
    clear_inputs();
    w8_if.swap_req   = 1'b0;
    w8_if.immediate  = 1'b0;
    w8_if.vblank     = 1'b0;
    w8_if.nmi_enable = 1'b0;
    w8_if.nmi_ack    = 1'b0;

    vecs[0]  = 9'b00000_0001;
    vecs[1]  = 9'b11000_0111;  // immediate swap request
    vecs[2]  = 9'b00000_0111;
    vecs[3]  = 9'b00000_0111;
    vecs[4]  = 9'b00000_0111;
    vecs[5]  = 9'b00000_1001;  // flip 5 cycles after request
    vecs[6]  = 9'b10010_1101;  // VBlank-synchronised request
    vecs[7]  = 9'b00110_1101;  // raw VBlank rise
    vecs[8]  = 9'b00110_1110;
    vecs[9]  = 9'b00110_1110;
    vecs[10] = 9'b00110_1110;
    vecs[11] = 9'b00110_1110;
    vecs[12] = 9'b00110_0000;  // flip 6 cycles after raw rise
    vecs[13] = 9'b00111_0001;
    vecs[14] = 9'b00010_0001;
    vecs[15] = 9'b00110_0001;
    vecs[16] = 9'b10110_0100;  // request coincides with VbRise: arm only
    vecs[17] = 9'b00111_0101;
    vecs[18] = 9'b00110_0101;  // VBlank held: no second rise
    vecs[19] = 9'b01110_0111;  // immediate while armed
    vecs[20] = 9'b00110_0111;
    vecs[21] = 9'b00110_0111;
    vecs[22] = 9'b00110_0111;
    vecs[23] = 9'b00000_1001;

    step();
    step();
    check("reset buf_sel",      32'(fs_if.buf_sel),         0);
    check("reset nmi_n",        32'(fs_if.nmi_n),           1);
    check("reset frame_count",  32'(fs_if.frame_count),     0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      fs_if.swap_req   = vecs[i].sr;
      fs_if.immediate  = vecs[i].im;
      fs_if.vblank     = vecs[i].vb;
      fs_if.nmi_enable = vecs[i].en;
      fs_if.nmi_ack    = vecs[i].ak;
      step();
      check($sformatf("vec%0d buf_sel", i),         32'(fs_if.buf_sel),         32'(vecs[i].buf_sel));
      check($sformatf("vec%0d swap_pending", i),    32'(fs_if.swap_pending),    32'(vecs[i].pend));
      check($sformatf("vec%0d cpu_write_block", i), 32'(fs_if.cpu_write_block), 32'(vecs[i].blk));
      check($sformatf("vec%0d nmi_n", i),           32'(fs_if.nmi_n),           32'(vecs[i].nmi_n));
    end
    check("table frame_count", 32'(fs_if.frame_count), 2);
    check("table flip_count",  32'(fs_if.flip_count),  3);

    // Reset in the middle of an immediate flip abandons it.
    clear_inputs();
    fs_if.swap_req  = 1'b1;
    fs_if.immediate = 1'b1;
    step();
    clear_inputs();
    step();
    check("pre-reset guard", 32'(fs_if.cpu_write_block), 1);
    rst_n = 1'b0;
    step();
    check("rst buf_sel",         32'(fs_if.buf_sel),         0);
    check("rst swap_pending",    32'(fs_if.swap_pending),    0);
    check("rst cpu_write_block", 32'(fs_if.cpu_write_block), 0);
    check("rst nmi_n",           32'(fs_if.nmi_n),           1);
    check("rst frame_count",     32'(fs_if.frame_count),     0);
    check("rst flip_count",      32'(fs_if.flip_count),      0);
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("abandoned flip buf_sel",    32'(fs_if.buf_sel),    0);
    check("abandoned flip flip_count", 32'(fs_if.flip_count), 0);

    // VBlank-synchronised flip 100 cycles after the request.
    fs_if.swap_req = 1'b1;
    step();
    fs_if.swap_req = 1'b0;
    check("armed swap_pending", 32'(fs_if.swap_pending), 1);
    repeat (100) step();
    check("armed no flip", 32'(fs_if.buf_sel), 0);
    fs_if.vblank = 1'b1;
    lat          = 0;
    blk_cnt      = 0;
    pend_prev    = 1'b0;
    pend_at_flip = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (fs_if.cpu_write_block) blk_cnt++;
      if (lat == 0 && fs_if.buf_sel) begin
        lat          = k;
        pend_at_flip = fs_if.swap_pending;
        check("pending before flip", 32'(pend_prev), 1);
      end
      pend_prev = fs_if.swap_pending;
    end
    check("vblank flip latency",      32'(lat),                6);
    check("vblank guard cycles",      32'(blk_cnt),            4);
    check("pending drops with flip",  32'(pend_at_flip),       0);
    check("vblank flip_count",        32'(fs_if.flip_count),   1);
    check("vblank frame_count",       32'(fs_if.frame_count),  1);
    fs_if.vblank = 1'b0;
    step();

    // Requests during GUARD queue exactly one extra flip, taken on the next VbRise.
    do_reset();
    fs_if.swap_req = 1'b1;
    step();
    fs_if.swap_req = 1'b0;
    fs_if.vblank   = 1'b1;
    step();
    step();
    check("queue guard entered", 32'(fs_if.cpu_write_block), 1);
    for (int k = 0; k < 3; k++) begin
      fs_if.swap_req = 1'b1;
      step();
    end
    fs_if.swap_req = 1'b0;
    wait_buf(1'b1, "queue first flip");
    check("queue rearmed pending", 32'(fs_if.swap_pending), 1);
    repeat (10) step();
    check("queue waits for vblank", 32'(fs_if.buf_sel),    1);
    check("queue one flip so far",  32'(fs_if.flip_count), 1);
    fs_if.vblank = 1'b0;
    step();
    fs_if.vblank = 1'b1;
    wait_buf(1'b0, "queue second flip");
    repeat (10) step();
    check("queue total flips",   32'(fs_if.flip_count),      2);
    check("queue buf_sel end",   32'(fs_if.buf_sel),         0);
    check("queue pending clear", 32'(fs_if.swap_pending),    0);
    check("queue guard clear",   32'(fs_if.cpu_write_block), 0);

    // NMI set/ack priority and enable-clear.
    clear_inputs();
    fs_if.nmi_enable = 1'b1;
    step();
    fs_if.vblank = 1'b1;
    step();
    fs_if.nmi_ack = 1'b1;
    step();
    check("nmi set beats ack", 32'(fs_if.nmi_n), 0);
    step();
    check("nmi acked", 32'(fs_if.nmi_n), 1);
    fs_if.nmi_ack = 1'b0;
    fs_if.vblank  = 1'b0;
    step();
    fs_if.vblank = 1'b1;
    step();
    step();
    check("nmi set again", 32'(fs_if.nmi_n), 0);
    fs_if.nmi_enable = 1'b0;
    step();
    check("nmi cleared by disable", 32'(fs_if.nmi_n), 1);
    clear_inputs();

    // 300 frames on the 8-bit frame counter instance, no swap requests.
    blk_cnt = 0;
    for (int f = 0; f < 300; f++) begin
      w8_if.vblank = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (w8_if.cpu_write_block) blk_cnt++;
      end
      w8_if.vblank = 1'b1;
      for (int k = 0; k < 5; k++) begin
        step();
        if (w8_if.cpu_write_block) blk_cnt++;
      end
    end
    check("w8 frame_count wrap",   32'(w8_if.frame_count), 44);
    check("w8 no write block",     32'(blk_cnt),           0);
    check("w8 no flips",           32'(w8_if.flip_count),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
